ysyx_23060203_axi_rd_rr_arb: RTL
================================

# ysyx_23060203_axi_rd_rr_arb

Round-robin arbiter that shares one AXI4 read channel (AR/R) between N requesters, such as IFU/ICache refill, LSU loads and a future DMA or debug port, ahead of the Xbar. It serves one transaction at a time, including bursts. Each accepted AR is latched, issued downstream and its R beats are routed back to the owner until `rlast`. Rotating priority guarantees no requester starves.

## Interface
- `N`, default 2: number of requesters, range 2..8; `GW = $clog2(N)`.
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `clk`  in  1  clock; all logic on rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `s_arvalid` in N, `s_arready` out N: per-requester AR handshake.
- `s_araddr` in N*AW, `s_arlen` in N*8, `s_arsize` in N*3, `s_arburst` in N*2, `s_arid` in N*4: requester i occupies slice i.
- `s_rvalid` out N, `s_rready` in N: per-requester R handshake.
- `s_rdata` out DW, `s_rresp` out 2, `s_rlast` out 1, `s_rid` out 4: broadcast to all requesters; qualified by `s_rvalid[i]`.
- `m_arvalid` out 1, `m_arready` in 1, `m_araddr` out AW, `m_arlen` out 8, `m_arsize` out 3, `m_arburst` out 2, `m_arid` out 4: downstream AR.
- `m_rvalid` in 1, `m_rready` out 1, `m_rdata` in DW, `m_rresp` in 2, `m_rlast` in 1, `m_rid` in 4: downstream R.

## Operation
- State machine: IDLE, ADDR, DATA. Registers:
  - `state`
  - `grant` (GW bits)
  - `prio` (GW bits, highest-priority index)
  - latched AR fields
- IDLE:
  - Winner is the first `i` with `s_arvalid[i]`, scanning `prio, prio+1, …` mod N.
  - `s_arready[winner]=1` combinationally; all other bits 0.
  - If any request is present: latch the winner's AR fields, set `grant<=winner`, go to ADDR.
- ADDR:
  - `m_arvalid=1`, driven with the latched fields.
  - All `s_arready=0`.
  - On `m_arready`, go to DATA.
- DATA:
  - `s_rvalid[grant]=m_rvalid`; all other `s_rvalid` bits 0.
  - `m_rready=s_rready[grant]`.
  - `s_rdata/rresp/rlast/rid` = the `m_*` values, passed through unmodified, including error responses.
  - On a handshake with `m_rlast=1`: go to IDLE and set `prio<=grant+1` (wraps N-1→0).
- `m_rready=0` outside DATA.
- `m_arvalid=0` outside ADDR.
- Non-power-of-two N: the mod-N wrap is explicit, and `prio` never holds a value ≥ N.
- A requester may deassert `s_arvalid` before it is granted; it is simply not selected.
- R beats arriving in IDLE or ADDR are not accepted (`m_rready=0`). Downstream never returns them under single-outstanding operation.

## Timing
- Reset (`rstn=0` at posedge): `state=IDLE`, `prio=0`, `grant=0`, latched AR fields 0. Combinationally this gives:
  - `m_arvalid=0`, `m_rready=0`
  - `s_rvalid=0`
  - `s_arready` all 0 while `rstn=0`
- Reset mid-transaction (ADDR or DATA) abandons the transaction. Downstream is reset by the same `rstn`.
- AR latency: requester handshake in cycle T → `m_arvalid` high in T+1.
- `m_arvalid` and the latched fields stay stable until `m_arready`.
- R path is combinational. Zero added latency per beat; back-pressure passes straight through `m_rready`.
- Turnaround: the final beat handshake in cycle T leaves state DATA; IDLE is active in T+1, so the next `s_arready` is possible in T+1.
- Minimum single-beat transaction is 3 cycles plus downstream latency.
- Simultaneous requests in IDLE: exactly one `s_arready` bit is set. After a grant to `g`, every other requester with a continuously asserted request is served within N-1 further transactions.

## Test plan
- Single request, N=2: `s_arvalid[1]`, addr `0x8000_0010`, `arlen=0`.
  - Same cycle: `s_arready=2'b10`.
  - Next cycle: `m_arvalid=1`, `m_araddr=0x8000_0010`.
  - Return beat `0xDEADBEEF`: it appears only on `s_rvalid[1]` with `s_rlast=1`; `prio=0` afterwards.
- Simultaneous requests after reset: `s_arvalid=2'b11` held.
  - Grant order: 0, then 1, then 0.
  - Exactly one `s_arready` bit per IDLE cycle.
- Burst: `arlen=3`, with `s_rready` low on beat 2 for 3 cycles.
  - `m_rready` is low for those 3 cycles.
  - 4 beats are delivered in order, `rlast` only on beat 4.
  - The other requester sees no `s_rvalid` throughout.
- Downstream AR stall: `m_arready` low for 5 cycles.
  - `m_arvalid` stays high with stable address.
  - No new `s_arready` is issued.
- Error passthrough: `m_rresp=2'b10` → `s_rresp=2'b10` on the owner, and arbitration proceeds normally.
- Reset in DATA after beat 1 of 4: the next cycle shows IDLE outputs with `prio=0`; a fresh request is then granted normally.

Source files
------------

// File: rtl/ysyx_23060203_axi_rd_rr_arb.sv
// Round-robin arbiter sharing one AXI4 read channel (AR/R) between N requesters.
// One transaction in flight at a time; R beats are routed back to the owner until rlast.
module ysyx_23060203_axi_rd_rr_arb #(
  parameter int N  = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  localparam int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rstn,

  input  logic [N-1:0]    s_arvalid,
  output logic [N-1:0]    s_arready,
  input  logic [N*AW-1:0] s_araddr,
  input  logic [N*8-1:0]  s_arlen,
  input  logic [N*3-1:0]  s_arsize,
  input  logic [N*2-1:0]  s_arburst,
  input  logic [N*4-1:0]  s_arid,

  output logic [N-1:0]    s_rvalid,
  input  logic [N-1:0]    s_rready,
  output logic [DW-1:0]   s_rdata,
  output logic [1:0]      s_rresp,
  output logic            s_rlast,
  output logic [3:0]      s_rid,

  output logic            m_arvalid,
  input  logic            m_arready,
  output logic [AW-1:0]   m_araddr,
  output logic [7:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic [1:0]      m_arburst,
  output logic [3:0]      m_arid,

  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [DW-1:0]   m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rlast,
  input  logic [3:0]      m_rid
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] prio_q, prio_d;
  logic [AW-1:0] arAddr_q, arAddr_d;
  logic [7:0]    arLen_q, arLen_d;
  logic [2:0]    arSize_q, arSize_d;
  logic [1:0]    arBurst_q, arBurst_d;
  logic [3:0]    arId_q, arId_d;

  logic [GW-1:0] winner;
  logic          anyReq;

  logic [AW-1:0] reqAddr  [N];
  logic [7:0]    reqLen   [N];
  logic [2:0]    reqSize  [N];
  logic [1:0]    reqBurst [N];
  logic [3:0]    reqId    [N];

  for (genvar i = 0; i < N; i++) begin : gUnpack
    assign reqAddr[i]  = s_araddr[i*AW +: AW];
    assign reqLen[i]   = s_arlen[i*8 +: 8];
    assign reqSize[i]  = s_arsize[i*3 +: 3];
    assign reqBurst[i] = s_arburst[i*2 +: 2];
    assign reqId[i]    = s_arid[i*4 +: 4];
  end

  // Scan prio, prio+1, ... with an explicit mod-N wrap so non-power-of-two N never indexes past N-1.
  always_comb begin
    int idx;
    logic [GW-1:0] sel;
    winner = prio_q;
    anyReq = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(prio_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      sel = GW'(idx);
      if (!anyReq && s_arvalid[sel]) begin
        anyReq = 1'b1;
        winner = sel;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    prio_d    = prio_q;
    arAddr_d  = arAddr_q;
    arLen_d   = arLen_q;
    arSize_d  = arSize_q;
    arBurst_d = arBurst_q;
    arId_d    = arId_q;
    s_arready = '0;
    s_rvalid  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;

    case (state_q)
      IDLE: begin
        if (anyReq) begin
          s_arready[winner] = 1'b1;
          grant_d   = winner;
          arAddr_d  = reqAddr[winner];
          arLen_d   = reqLen[winner];
          arSize_d  = reqSize[winner];
          arBurst_d = reqBurst[winner];
          arId_d    = reqId[winner];
          state_d   = ADDR;
        end
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        s_rvalid[grant_q] = m_rvalid;
        m_rready          = s_rready[grant_q];
        if (m_rvalid && s_rready[grant_q] && m_rlast) begin
          state_d = IDLE;
          prio_d  = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The grant strobe must not escape while reset is held, even before the first reset edge.
    if (!rstn) begin
      s_arready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      prio_q    <= '0;
      arAddr_q  <= '0;
      arLen_q   <= '0;
      arSize_q  <= '0;
      arBurst_q <= '0;
      arId_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      prio_q    <= prio_d;
      arAddr_q  <= arAddr_d;
      arLen_q   <= arLen_d;
      arSize_q  <= arSize_d;
      arBurst_q <= arBurst_d;
      arId_q    <= arId_d;
    end
  end

  assign m_araddr  = arAddr_q;
  assign m_arlen   = arLen_q;
  assign m_arsize  = arSize_q;
  assign m_arburst = arBurst_q;
  assign m_arid    = arId_q;

  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;
  assign s_rid   = m_rid;

endmodule
